// File: rtl/fb_line_reader_if.sv
// fb_line_reader_if: framebuffer RAM read port, pixel stream and line control of fb_line_reader
interface fb_line_reader_if #(
   parameter int ADDRW = 17,
   parameter int CIDXW = 4
);
   logic             frame;
   logic             start;
   logic             rd_en;
   logic [ADDRW-1:0] rd_addr;
   logic [CIDXW-1:0] rd_data;
   logic [CIDXW-1:0] out_cidx;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             line_done;
   modport master (
      input  frame, start, rd_data, out_ready,
      output rd_en, rd_addr, out_cidx, out_valid, busy, line_done
   );
   modport slave (
      output frame, start, rd_data, out_ready,
      input  rd_en, rd_addr, out_cidx, out_valid, busy, line_done
   );
endinterface

// File: rtl/fb_line_reader.sv
// fb_line_reader: fetches one framebuffer row per line request and streams it scaled by SCALE on both axes.
// Optional: define FB_LINE_READER_STATS_EN to add the 16-bit saturating stall_cnt underrun counter.
module fb_line_reader #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240,
   parameter int CIDXW  = 4,
   parameter int SCALE  = 2,
   parameter int ADDRW  = $clog2(WIDTH*HEIGHT)
) (
   input  logic clk,
   input  logic rst_n,
   fb_line_reader_if.master bus
`ifdef FB_LINE_READER_STATS_EN
   ,
   output logic [15:0] stall_cnt
`endif
);
   localparam int CW = WIDTH  > 1 ? $clog2(WIDTH)  : 1;
   localparam int RW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
   localparam int SW = SCALE  > 1 ? $clog2(SCALE)  : 1;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t           state, state_nx, st;
   logic [CW-1:0]    col, col_nx, c;
   logic [RW-1:0]    row;
   logic [SW-1:0]    rep, hcnt;
   logic [ADDRW-1:0] base, b;
   logic [CIDXW-1:0] mem [3];
   logic [1:0]       wp, rp, cnt;
   logic             v2, issue, done, beat, pop, room, last;

   assign bus.out_valid = cnt != 2'd0;
   assign bus.out_cidx  = mem[rp];
   assign bus.busy      = state != IDLE;
   assign beat = bus.out_valid && bus.out_ready;
   assign pop  = beat && hcnt == SW'(SCALE-1);
   // a slot exists when what the FIFO will hold after this cycle's pop, plus reads still in the RAM pipe, is under 3
   assign room = ({1'b0, cnt} + 3'(bus.rd_en) + 3'(v2) - 3'(pop)) < 3'd3;
   assign last = pop && cnt == 2'd1 && !bus.rd_en && !v2;

   // next state and read issue; frame behaves as an immediate return to IDLE on row 0 so a same-cycle start is honoured
   always_comb begin
      st       = bus.frame ? IDLE : state;
      c        = bus.frame ? '0 : col;
      b        = bus.frame ? '0 : base;
      state_nx = st;
      col_nx   = c;
      issue    = 1'b0;
      done     = 1'b0;
      case (st)
         IDLE: if (bus.start) begin
            issue    = 1'b1;
            col_nx   = CW'(WIDTH > 1 ? 1 : 0);
            state_nx = WIDTH > 1 ? FETCH : DRAIN;
         end
         FETCH: if (room) begin
            issue    = 1'b1;
            col_nx   = col == CW'(WIDTH-1) ? '0 : col + 1'b1;
            state_nx = col == CW'(WIDTH-1) ? DRAIN : FETCH;
         end
         DRAIN: if (last) begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // state, RAM request, FIFO and row/repeat bookkeeping
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         col           <= '0;
         row           <= '0;
         rep           <= '0;
         base          <= '0;
         hcnt          <= '0;
         wp            <= '0;
         rp            <= '0;
         cnt           <= '0;
         v2            <= 1'b0;
         mem           <= '{default: '0};
         bus.rd_en     <= 1'b0;
         bus.rd_addr   <= '0;
         bus.line_done <= 1'b0;
      end else begin
         state         <= state_nx;
         col           <= col_nx;
         bus.rd_en     <= issue;
         bus.line_done <= done;
         v2            <= bus.rd_en && !bus.frame;
         if (issue)
            bus.rd_addr <= b + ADDRW'(c);
         if (bus.frame) begin
            row  <= '0;
            rep  <= '0;
            base <= '0;
            hcnt <= '0;
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
         end else begin
            if (v2) begin
               mem[wp] <= bus.rd_data;
               wp      <= wp == 2'd2 ? 2'd0 : wp + 2'd1;
            end
            if (pop)
               rp <= rp == 2'd2 ? 2'd0 : rp + 2'd1;
            if (beat)
               hcnt <= pop ? '0 : hcnt + 1'b1;
            cnt <= cnt + 2'(v2) - 2'(pop);
            if (done) begin
               rep  <= rep == SW'(SCALE-1) ? '0 : rep + 1'b1;
               row  <= rep != SW'(SCALE-1) ? row : row == RW'(HEIGHT-1) ? '0 : row + 1'b1;
               base <= rep != SW'(SCALE-1) ? base : row == RW'(HEIGHT-1) ? '0 : base + ADDRW'(WIDTH);
            end
         end
      end
   end

`ifdef FB_LINE_READER_STATS_EN
   logic seen;

   // count underrun cycles once a line has delivered its first beat
   always_ff @(posedge clk) begin
      if (!rst_n || bus.frame) begin
         stall_cnt <= '0;
         seen      <= 1'b0;
      end else begin
         seen <= !done && (seen || beat);
         if (seen && bus.busy && bus.out_ready && !bus.out_valid && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif
endmodule
